// File: rtl/sync_debouncer_pkg.sv
// sync_debouncer_pkg: shared FSM state type and glitch counter width for sync_debouncer.
package sync_debouncer_pkg;
  typedef enum logic {STABLE, SETTLING} debounce_state_t;
  localparam int GLITCH_CNT_WIDTH = 8;
endpackage

// File: rtl/synchronizer.sv
// synchronizer: metastability flop chain; reusable by any clock-crossing path.
module synchronizer #(
  parameter int STAGES      = 2,
  parameter bit RESET_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in,
  output logic out
);
  logic [STAGES-1:0] s;
  if (STAGES < 2) begin : g_bad_stages
    $error("synchronizer: STAGES must be >= 2");
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) s <= {STAGES{RESET_LEVEL}};
    else          s <= {s[STAGES-2:0], in};
  assign out = s[STAGES-1];
endmodule

// File: rtl/sync_debouncer.sv
// sync_debouncer: synchronises and debounces a raw level input; optional glitch counter
// enabled by defining SYNC_DEBOUNCER_GLITCH_CNT_EN.
module sync_debouncer
  import sync_debouncer_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter bit RESET_LEVEL     = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in,
  output logic out,
  output logic out_changed
`ifdef SYNC_DEBOUNCER_GLITCH_CNT_EN
  ,
  output logic [GLITCH_CNT_WIDTH-1:0] glitch_cnt
`endif
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  if (SYNC_STAGES < 2) begin : g_bad_stages
    $error("sync_debouncer: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_cycles
    $error("sync_debouncer: DEBOUNCE_CYCLES must be >= 1");
  end
  debounce_state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic s_sync, diff, accept, out_nxt;
  synchronizer #(.STAGES(SYNC_STAGES), .RESET_LEVEL(RESET_LEVEL)) u_sync (
    .clk(clk), .reset_n(reset_n), .in(in), .out(s_sync)
  );
  assign diff = s_sync != out;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state       <= STABLE;
      cnt         <= '0;
      out         <= RESET_LEVEL;
      out_changed <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      out         <= out_nxt;
      out_changed <= accept;
    end
  always_comb begin
    state_nxt = (state == STABLE) ? ((diff && DEBOUNCE_CYCLES > 1) ? SETTLING : STABLE)
                                  : ((!diff || cnt == LAST) ? STABLE : SETTLING);
  end
  // A change is accepted on the edge that completes DEBOUNCE_CYCLES differing cycles.
  always_comb begin
    accept  = diff && ((state == STABLE) ? (DEBOUNCE_CYCLES == 1) : (cnt == LAST));
    out_nxt = accept ? s_sync : out;
    cnt_nxt = (diff && !accept) ? ((state == SETTLING) ? cnt + 1'b1 : CW'(1)) : '0;
  end
`ifdef SYNC_DEBOUNCER_GLITCH_CNT_EN
  logic glitch_evt;
  assign glitch_evt = (state == SETTLING) && !diff;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n)                          glitch_cnt <= '0;
    else if (glitch_evt && glitch_cnt != '1) glitch_cnt <= glitch_cnt + 1'b1;
`endif
endmodule

// File: tb/tb_sync_debouncer.sv
// tb_sync_debouncer: directed and random checks of sync_debouncer (DEBOUNCE_CYCLES 4 and 1)
// against a run-length reference model; glitch checks when SYNC_DEBOUNCER_GLITCH_CNT_EN is defined.
module tb_sync_debouncer;
  localparam int SS = 2;
  localparam int DA = 4;
  localparam int DB = 1;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic in_a = 1'b1, in_b = 1'b1;
  logic out_a, chg_a, out_b, chg_b;
`ifdef SYNC_DEBOUNCER_GLITCH_CNT_EN
  logic [7:0] glitch_a, glitch_b;
`endif
  int tests = 0, fails = 0;
  logic [SS-1:0] h[2];
  logic mout[2], mchg[2];
  int run[2], mg[2];
  always #5 clk = ~clk;
  sync_debouncer #(.SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DA), .RESET_LEVEL(1'b0)) dut_a (
    .clk(clk), .reset_n(reset_n), .in(in_a), .out(out_a), .out_changed(chg_a)
`ifdef SYNC_DEBOUNCER_GLITCH_CNT_EN
    , .glitch_cnt(glitch_a)
`endif
  );
  sync_debouncer #(.SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB), .RESET_LEVEL(1'b0)) dut_b (
    .clk(clk), .reset_n(reset_n), .in(in_b), .out(out_b), .out_changed(chg_b)
`ifdef SYNC_DEBOUNCER_GLITCH_CNT_EN
    , .glitch_cnt(glitch_b)
`endif
  );
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      h[i] = '0; mout[i] = 1'b0; mchg[i] = 1'b0; run[i] = 0; mg[i] = 0;
    end
  endfunction
  // Output flips once the synchronised input has disagreed with it for d consecutive edges.
  function automatic void model_step(input int i, input logic v, input int d);
    logic sync;
    sync = h[i][SS-1];
    h[i] = {h[i][SS-2:0], v};
    mchg[i] = 1'b0;
    if (sync != mout[i]) begin
      run[i]++;
      if (run[i] == d) begin
        mout[i] = sync; mchg[i] = 1'b1; run[i] = 0;
      end
    end else begin
      if (run[i] > 0 && mg[i] < 255) mg[i]++;
      run[i] = 0;
    end
  endfunction
  task automatic tick(input logic va, input logic vb);
    in_a = va; in_b = vb;
    @(posedge clk);
    model_step(0, va, DA);
    model_step(1, vb, DB);
    #1;
    check("out_a", out_a, mout[0]);
    check("chg_a", chg_a, mchg[0]);
    check("out_b", out_b, mout[1]);
    check("chg_b", chg_b, mchg[1]);
`ifdef SYNC_DEBOUNCER_GLITCH_CNT_EN
    check("glitch_a", glitch_a, 8'(mg[0]));
    check("glitch_b", glitch_b, 8'(mg[1]));
`endif
    @(negedge clk);
  endtask
  initial begin
    int g;
    logic [5:0] pat;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_out", out_a, 1'b0);
    check("rst_chg", chg_a, 1'b0);
    check("rst_out_b", out_b, 1'b0);
`ifdef SYNC_DEBOUNCER_GLITCH_CNT_EN
    check("rst_glitch", glitch_a, 8'd0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick(1'b0, 1'b0);
      check("rel_hold", out_a, 1'b0);
    end
    for (int k = 1; k <= 6; k++) begin
      tick(1'b1, 1'b1);
      check("rise_a", out_a, k >= 6);
      check("rise_pulse_a", chg_a, k == 6);
      check("rise_b", out_b, k >= 3);
      check("rise_pulse_b", chg_b, k == 3);
    end
    tick(1'b1, 1'b1);
    check("rise_pulse_end", chg_a, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      tick(1'b0, 1'b0);
      check("fall_a", out_a, k < 6);
      check("fall_pulse_a", chg_a, k == 6);
    end
    g = mg[0];
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    for (int k = 0; k < 8; k++) begin
      tick(1'b0, 1'b0);
      check("glitch_out", out_a, 1'b0);
      check("glitch_chg", chg_a, 1'b0);
    end
`ifdef SYNC_DEBOUNCER_GLITCH_CNT_EN
    check("glitch_one", glitch_a, 8'(g + 1));
`endif
    g = mg[0];
    pat = 6'b101101;
    for (int k = 5; k >= 0; k--) tick(pat[k], pat[k]);
    for (int k = 1; k <= 10; k++) begin
      tick(1'b1, 1'b1);
      check("bounce_out", out_a, k >= 5);
    end
`ifdef SYNC_DEBOUNCER_GLITCH_CNT_EN
    check("bounce_glitch", glitch_a, 8'(g + 2));
`endif
    repeat (8) tick(1'b0, 1'b0);
    check("pre_mid_out", out_a, 1'b0);
    repeat (4) tick(1'b1, 1'b1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_out", out_a, 1'b0);
    check("mid_rst_chg", chg_a, 1'b0);
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("mid_rst_hold", out_a, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick(1'b1, 1'b1);
      check("requal_out", out_a, k >= 6);
      check("requal_chg", chg_a, k == 6);
    end
    for (int k = 0; k < 3000; k++)
      tick(($urandom_range(0, 5) == 0) ? ~in_a : in_a, ($urandom_range(0, 2) == 0) ? ~in_b : in_b);
`ifdef SYNC_DEBOUNCER_GLITCH_CNT_EN
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 300; k++) begin
      repeat (2) tick(1'b1, 1'b0);
      repeat (3) tick(1'b0, 1'b0);
    end
    check("sat_glitch", glitch_a, 8'd255);
    check("sat_out", out_a, 1'b0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
